// File: rtl/ps2_mouse_cmd_tx.sv
// PS/2 host-to-device command transmitter.
// Sends the enable/disable data reporting byte over open-drain clock/data enables.
module ps2_mouse_cmd_tx #(
    parameter int         INHIBIT_CYCLES = 6000,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0] ENABLE_CMD     = 8'hF4,
    parameter logic [7:0] DISABLE_CMD    = 8'hF5
) (
    input  logic iClk,
    input  logic iResetn,
    input  logic iStart,
    input  logic iEnable,
    input  logic iPS2Clk,
    input  logic iPS2Dat,
    output logic oPS2ClkOe,
    output logic oPS2DatOe,
    output logic oBusy,
    output logic oDone,
    output logic oError
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_ACK,
        S_WAIT,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic          r_clk_s1;
    logic          r_clk_s2;
    logic          r_clk_s3;
    logic          r_dat_s1;
    logic          r_dat_s2;
    logic [IW-1:0] r_inh_cnt;
    logic [TW-1:0] r_to_cnt;
    logic [3:0]    r_edge_cnt;
    logic [10:0]   r_bits;
    logic          r_err;

    logic [7:0] w_cmd;
    logic       w_fall;
    logic       w_to_run;
    logic       w_timeout;

    assign w_cmd     = iEnable ? ENABLE_CMD : DISABLE_CMD;
    assign w_fall    = r_clk_s3 & ~r_clk_s2;
    assign w_to_run  = (r_state == S_SEND) || (r_state == S_ACK) ||
                       (r_state == S_WAIT);
    assign w_timeout = w_to_run && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge iClk or negedge iResetn) begin
        if (!iResetn) begin
            r_state    <= S_IDLE;
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_s3   <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
            r_inh_cnt  <= '0;
            r_to_cnt   <= '0;
            r_edge_cnt <= '0;
            r_bits     <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_clk_s1 <= iPS2Clk;
            r_clk_s2 <= r_clk_s1;
            r_clk_s3 <= r_clk_s2;
            r_dat_s1 <= iPS2Dat;
            r_dat_s2 <= r_dat_s1;
            unique case (r_state)
                S_IDLE: begin
                    r_inh_cnt <= '0;
                    if (iStart) begin
                        // Frame image: stop, odd parity, byte, start (LSB out first)
                        r_bits <= {1'b1, ~^w_cmd, w_cmd, 1'b0};
                        r_err  <= 1'b0;
                    end
                end
                S_INHIBIT: r_inh_cnt <= r_inh_cnt + IW'(1);
                S_REQ: begin
                    r_to_cnt   <= '0;
                    r_edge_cnt <= '0;
                end
                S_SEND, S_ACK, S_WAIT: begin
                    r_to_cnt <= r_to_cnt + TW'(1);
                    if (w_timeout) begin
                        r_err <= 1'b1;
                    end else if (w_fall && r_state == S_SEND) begin
                        r_edge_cnt <= r_edge_cnt + 4'd1;
                        r_bits     <= {1'b1, r_bits[10:1]};
                    end else if (w_fall && r_state == S_ACK) begin
                        r_err <= r_dat_s2;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next    = r_state;
        oPS2ClkOe = 1'b0;
        oPS2DatOe = 1'b0;
        oBusy     = (r_state != S_IDLE);
        oDone     = 1'b0;
        oError    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (iStart) w_next = S_INHIBIT;
            end
            S_INHIBIT: begin
                oPS2ClkOe = 1'b1;
                if (r_inh_cnt == IW'(INHIBIT_CYCLES - 1)) w_next = S_REQ;
            end
            S_REQ: begin
                oPS2ClkOe = 1'b1;
                oPS2DatOe = 1'b1;
                w_next    = S_SEND;
            end
            S_SEND: begin
                oPS2DatOe = ~r_bits[0];
                if (w_timeout) w_next = S_DONE;
                else if (w_fall && r_edge_cnt == 4'd9) w_next = S_ACK;
            end
            S_ACK: begin
                if (w_timeout) w_next = S_DONE;
                else if (w_fall) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_timeout) w_next = S_DONE;
                else if (r_clk_s2 && r_dat_s2) w_next = S_DONE;
            end
            S_DONE: begin
                oDone  = 1'b1;
                oError = r_err;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ps2_mouse_cmd_tx.sv
// Bench for ps2_mouse_cmd_tx: device-side clock/data model with frame capture.
// Scaled inhibit/timeout lengths keep the run short.
module tb_ps2_mouse_cmd_tx;

    localparam int INH = 60;
    localparam int TO  = 3000;

    logic clk = 1'b0;
    logic iResetn;
    logic iStart;
    logic iEnable;
    logic dev_clk;
    logic dev_dat;
    logic oPS2ClkOe;
    logic oPS2DatOe;
    logic oBusy;
    logic oDone;
    logic oError;

    wire ps2_clk = dev_clk & ~oPS2ClkOe;
    wire ps2_dat = dev_dat & ~oPS2DatOe;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int n_inh    = 0;
    int n_req    = 0;
    int n_done   = 0;
    int n_stray  = 0;
    int req_cyc  = 0;
    int done_cyc = 0;
    logic       done_err = 1'b0;
    logic [1:0] done_oe  = 2'b00;

    ps2_mouse_cmd_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .iClk     (clk),
        .iResetn  (iResetn),
        .iStart   (iStart),
        .iEnable  (iEnable),
        .iPS2Clk  (ps2_clk),
        .iPS2Dat  (ps2_dat),
        .oPS2ClkOe(oPS2ClkOe),
        .oPS2DatOe(oPS2DatOe),
        .oBusy    (oBusy),
        .oDone    (oDone),
        .oError   (oError)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (oPS2ClkOe && !oPS2DatOe) n_inh <= n_inh + 1;
        if (oPS2ClkOe && oPS2DatOe) begin
            n_req   <= n_req + 1;
            req_cyc <= cyc;
        end
        if (oDone) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc;
            done_err <= oError;
            done_oe  <= {oPS2ClkOe, oPS2DatOe};
        end
        if (oError && !oDone) n_stray <= n_stray + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic [10:0] f;
        f[0]   = 1'b0;
        f[8:1] = b;
        f[9]   = ($countones(b) % 2 == 0);
        f[10]  = 1'b1;
        return f;
    endfunction

    task automatic pulse_start(input logic en);
        @(negedge clk);
        iEnable = en;
        iStart  = 1'b1;
        @(negedge clk);
        iStart  = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (n_done != d0) break;
        end
        @(negedge clk);
    endtask

    // Device side: waits for the request, then clocks n falling edges.
    task automatic dev_frame(input int n, input bit ack, input int start_at,
                             input int rst_at, output logic [10:0] cap,
                             output bit got);
        int h;
        h   = $urandom_range(12, 25);
        cap = '0;
        got = 1'b0;
        for (int k = 0; k < INH + 50; k++) begin
            @(negedge clk);
            if (!oPS2ClkOe && oPS2DatOe) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) return;
        cap[0] = ps2_dat;
        for (int e = 1; e <= n; e++) begin
            repeat (h) @(negedge clk);
            dev_clk = 1'b0;
            if (e == start_at) begin
                iStart  = 1'b1;
                iEnable = ~iEnable;
                @(negedge clk);
                iStart  = 1'b0;
            end
            if (e == rst_at) begin
                #2 iResetn = 1'b0;
                #1;
                check("rst_async_clkoe", 32'(oPS2ClkOe), 32'd0);
                check("rst_async_datoe", 32'(oPS2DatOe), 32'd0);
                check("rst_async_busy", 32'(oBusy), 32'd0);
                dev_clk = 1'b1;
                return;
            end
            repeat (h) @(negedge clk);
            dev_clk = 1'b1;
            if (e <= 10) cap[e] = ps2_dat;
            if (e == 10 && ack) dev_dat = 1'b0;
            if (e == 11) dev_dat = 1'b1;
        end
    endtask

    task automatic run_frame(input logic en, input bit ack, input int start_at);
        int i0, r0, d0, s0;
        logic [10:0] cap;
        bit got;
        i0 = n_inh;
        r0 = n_req;
        d0 = n_done;
        s0 = n_stray;
        pulse_start(en);
        dev_frame(11, ack, start_at, 0, cap, got);
        check("req_seen", 32'(got), 32'd1);
        wait_done(d0, 400);
        check("frame_bits", 32'(cap), 32'(frame_of(en ? 8'hF4 : 8'hF5)));
        check("inhibit_len", 32'(n_inh - i0), 32'(INH));
        check("req_len", 32'(n_req - r0), 32'd1);
        check("done_count", 32'(n_done - d0), 32'd1);
        check("done_error", 32'(done_err), 32'(!ack));
        check("stray_error", 32'(n_stray - s0), 32'd0);
        check("busy_after", 32'(oBusy), 32'd0);
        if (start_at != 0) begin
            repeat (INH + 40) @(negedge clk);
            check("no_requeue_inh", 32'(n_inh - i0), 32'(INH));
            check("no_requeue_busy", 32'(oBusy), 32'd0);
        end
    endtask

    task automatic run_timeout(input bit fall_on_to);
        int d0;
        logic [10:0] cap;
        bit got;
        d0 = n_done;
        pulse_start(1'($urandom_range(0, 1)));
        dev_frame(4, 1'b0, 0, 0, cap, got);
        check("to_req_seen", 32'(got), 32'd1);
        if (fall_on_to) begin
            for (int k = 0; k < TO; k++) begin
                if (cyc == req_cyc + TO - 2) break;
                @(negedge clk);
            end
            dev_clk = 1'b0;
        end
        wait_done(d0, TO + 100);
        dev_clk = 1'b1;
        check("to_done_count", 32'(n_done - d0), 32'd1);
        check("to_latency", 32'(done_cyc - req_cyc), 32'(TO + 1));
        check("to_error", 32'(done_err), 32'd1);
        check("to_lines_released", 32'(done_oe), 32'd0);
        repeat (3) @(negedge clk);
        check("to_busy_after", 32'(oBusy), 32'd0);
    endtask

    initial begin
        int d0;
        logic [10:0] cap;
        bit got;
        iResetn = 1'b0;
        iStart  = 1'b0;
        iEnable = 1'b0;
        dev_clk = 1'($urandom_range(0, 1));
        dev_dat = 1'($urandom_range(0, 1));
        repeat (5) @(negedge clk);
        check("reset_clkoe", 32'(oPS2ClkOe), 32'd0);
        check("reset_datoe", 32'(oPS2DatOe), 32'd0);
        check("reset_busy", 32'(oBusy), 32'd0);
        check("reset_done", 32'(oDone), 32'd0);
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        iResetn = 1'b1;
        d0 = n_done;
        repeat (300) @(negedge clk);
        check("idle_busy", 32'(oBusy), 32'd0);
        check("idle_lines", 32'({oPS2ClkOe, oPS2DatOe}), 32'd0);
        check("idle_no_done", 32'(n_done - d0), 32'd0);

        run_frame(1'b1, 1'b1, 0);
        run_frame(1'b0, 1'b1, 0);
        run_frame(1'b1, 1'b0, 0);
        for (int t = 0; t < 3; t++)
            run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);

        run_timeout(1'b0);
        run_timeout(1'b1);

        run_frame(1'($urandom_range(0, 1)), 1'b1, 5);

        d0 = n_done;
        pulse_start(1'($urandom_range(0, 1)));
        dev_frame(11, 1'b1, 0, 6, cap, got);
        check("rst_req_seen", 32'(got), 32'd1);
        repeat (4) @(negedge clk);
        dev_dat = 1'b1;
        iResetn = 1'b1;
        repeat (100) @(negedge clk);
        check("rst_no_done", 32'(n_done - d0), 32'd0);
        check("rst_busy_after", 32'(oBusy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
